// File: rtl/trigger_frame_tx.sv
// Builds one fixed-format trigger Ethernet frame on request and streams it as
// 32-bit words into the MAC transmit AXI-stream write channel (MAC adds FCS).
module trigger_frame_tx #(
  parameter int NUM_WORDS = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Send,
  input  logic [159:0] FrameHeader,
  input  logic [31:0]  Message,
  output logic [31:0]  RvviAxiWdata,
  output logic [3:0]   RvviAxiWstrb,
  output logic         RvviAxiWlast,
  output logic         RvviAxiWvalid,
  input  logic         RvviAxiWready,
  output logic         Busy,
  output logic         Done,
  output logic [7:0]   DropCount
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [159:0]   hdr_q, hdr_d;
  logic [31:0]    msg_q, msg_d;
  logic [7:0]     drop_q, drop_d;
  logic [31:0]    word_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hdr_q   <= '0;
      msg_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      msg_q   <= msg_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    msg_d   = msg_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (Send) begin
          hdr_d   = FrameHeader;
          msg_d   = Message;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Valid is implied by being in SEND, so ready alone marks a handshake.
        if (RvviAxiWready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((state_q != IDLE) && Send && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Data is a mux of registered snapshot and index only; ready never reaches it.
  always_comb begin
    word_sel = '0;
    case (idx_q)
      8'd0:    word_sel = hdr_q[31:0];
      8'd1:    word_sel = hdr_q[63:32];
      8'd2:    word_sel = hdr_q[95:64];
      8'd3:    word_sel = hdr_q[127:96];
      8'd4:    word_sel = hdr_q[159:128];
      8'd5:    word_sel = msg_q;
      default: word_sel = '0;
    endcase
  end

  assign RvviAxiWvalid = (state_q == SEND);
  assign RvviAxiWdata  = (state_q == SEND) ? word_sel : 32'h0;
  assign RvviAxiWstrb  = (state_q == SEND) ? 4'hF : 4'h0;
  assign RvviAxiWlast  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign Busy          = (state_q != IDLE);
  assign Done          = (state_q == DONE);
  assign DropCount     = drop_q;

endmodule

// File: tb/tb_trigger_frame_tx.sv
// Directed self-checking bench for trigger_frame_tx: reset, nominal frame,
// back-pressure, snapshot isolation, drop counting, mid-frame reset, back-to-back.
module tb_trigger_frame_tx;

  localparam int NW = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         Send;
  logic [159:0] hdr;
  logic [31:0]  msg;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         ready;
  logic         busy;
  logic         done;
  logic [7:0]   drop;

  logic [31:0]  exp_w [NW];
  int           errors = 0;
  int           checks = 0;

  trigger_frame_tx #(.NUM_WORDS(NW)) dut (
    .clk           (clk),
    .reset         (reset),
    .Send          (Send),
    .FrameHeader   (hdr),
    .Message       (msg),
    .RvviAxiWdata  (wdata),
    .RvviAxiWstrb  (wstrb),
    .RvviAxiWlast  (wlast),
    .RvviAxiWvalid (wvalid),
    .RvviAxiWready (ready),
    .Busy          (busy),
    .Done          (done),
    .DropCount     (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One frame from a Send pulse in IDLE; checks every handshake against exp_w.
  task automatic run_frame(input bit toggle, input bit chg_msg, input bit pulse_send);
    int          h;
    bit          done_seen;
    bit          stalled;
    logic [31:0] prev_d;
    logic        prev_l;
    h = 0; done_seen = 0; stalled = 0; prev_d = '0; prev_l = 1'b0;
    Send = 1'b1; ready = 1'b1;
    tick();
    Send = 1'b0;
    for (int c = 1; c < 200 && !done_seen; c++) begin
      ready = toggle ? ((c % 3) == 1) : 1'b1;
      if (chg_msg && c == 2) msg = 32'h12345678;
      Send = pulse_send && (c == 3 || c == 5 || c == 7);
      if (c == 1) chk("valid_latency", wvalid, 1);
      if (stalled) begin
        chk("stall_valid", wvalid, 1);
        chk("stall_data", wdata, prev_d);
        chk("stall_last", wlast, prev_l);
      end
      if (wvalid && ready) begin
        chk("word_in_range", (h < NW), 1);
        if (h < NW) begin
          chk($sformatf("data_w%0d", h), wdata, exp_w[h]);
          chk($sformatf("last_w%0d", h), wlast, (h == NW - 1));
          chk("strb", wstrb, 4'hF);
        end
        h++;
      end
      stalled = wvalid && !ready;
      prev_d  = wdata;
      prev_l  = wlast;
      if (done) done_seen = 1;
      tick();
    end
    Send = 1'b0;
    ready = 1'b1;
    chk("handshakes", h, NW);
    chk("done_seen", done_seen, 1);
    chk("busy_after", busy, 0);
    msg = 32'hDEADBEEF;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int prev_v;
    int last_rise;
    exp_w[0] = 32'h11116843;
    exp_w[1] = 32'h16544502;
    exp_w[2] = 32'h8f540000;
    exp_w[3] = 32'h7274005c;
    exp_w[4] = 32'h6e696769;
    exp_w[5] = 32'hDEADBEEF;
    for (int i = 6; i < NW; i++) exp_w[i] = 32'h0;

    hdr   = {32'h6e696769, 32'h7274005c, 32'h8f540000, 32'h16544502, 32'h11116843};
    msg   = 32'hDEADBEEF;
    Send  = 1'b0;
    ready = 1'b0;
    reset = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", wvalid, 0);
    chk("rst_last", wlast, 0);
    chk("rst_data", wdata, 0);
    chk("rst_strb", wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", wvalid, 0);

    // Nominal frame, ready tied high, cycle-exact
    Send = 1'b1; ready = 1'b1;
    tick();
    Send = 1'b0;
    for (int c = 1; c <= NW; c++) begin
      chk($sformatf("t1_valid_c%0d", c), wvalid, 1);
      chk($sformatf("t1_data_c%0d", c), wdata, exp_w[c-1]);
      chk($sformatf("t1_last_c%0d", c), wlast, (c == NW));
      chk("t1_strb", wstrb, 4'hF);
      chk("t1_done", done, 0);
      chk("t1_busy", busy, 1);
      tick();
    end
    chk("t1_valid_c16", wvalid, 0);
    chk("t1_last_c16", wlast, 0);
    chk("t1_done_c16", done, 1);
    chk("t1_busy_c16", busy, 1);
    tick();
    chk("t1_done_c17", done, 0);
    chk("t1_busy_c17", busy, 0);
    chk("t1_drop", drop, 0);

    // Back-pressure 1,0,0,1,...
    run_frame(1'b1, 1'b0, 1'b0);
    chk("t2_drop", drop, 0);

    // Message change after snapshot plus three Send pulses while busy
    run_frame(1'b0, 1'b1, 1'b1);
    chk("t3_drop", drop, 3);
    run_frame(1'b0, 1'b0, 1'b0);
    chk("t4_drop_kept", drop, 3);

    // Asynchronous reset at word 7
    Send = 1'b1; ready = 1'b1;
    tick();
    Send = 1'b0;
    repeat (7) tick();
    chk("t5_pre_valid", wvalid, 1);
    chk("t5_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", wvalid, 0);
    chk("t5_last", wlast, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_data", wdata, 0);
    chk("t5_drop", drop, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_frame(1'b0, 1'b0, 1'b0);

    // Send held high: back-to-back frames every 17 cycles, DropCount saturates
    Send = 1'b1; ready = 1'b1;
    prev_v = 0;
    last_rise = -1;
    for (int n = 1; n <= 350; n++) begin
      tick();
      if (wvalid && prev_v == 0) begin
        if (last_rise >= 0) chk("t6_period", n - last_rise, 17);
        last_rise = n;
      end
      prev_v = wvalid;
      if (n == 1) chk("t6_first_start", wvalid, 1);
      if (n == 17) chk("t6_drop_17", drop, 16);
      if (n == 300) chk("t6_drop_300", drop, 8'hFF);
    end
    chk("t6_drop_end", drop, 8'hFF);
    Send = 1'b0;
    repeat (20) tick();
    chk("t6_idle", busy, 0);
    chk("t6_drop_hold", drop, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trigger_frame_tx.md
Name: trigger_frame_tx

Overview:
- Transmit-side companion to the RVVI trigger-frame scanner.
- On request, builds one fixed-format trigger Ethernet frame and streams it as 32-bit words into the MAC transmit AXI-stream write channel.
- Frame layout: 5 header words (dst/src MAC, ethertype, tag), one 32-bit message word, then zero padding up to the minimum frame length. The MAC appends the FCS.
- Used to arm a remote ILA or a peer board over the RVVI Ethernet link.

Parameters:
- NUM_WORDS, 15, total 32-bit words per frame before FCS (15 words = 60 bytes = Ethernet minimum); legal range 6..255.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- Send  input  1  request to transmit one frame; sampled on the rising edge
- FrameHeader  input  160  header words; word i = FrameHeader[(i+1)*32-1:i*32], i=0..4, same packing as the scanner's compare string
- Message  input  32  message word carried in word 5
- RvviAxiWdata  output  32  stream data
- RvviAxiWstrb  output  4  byte strobes
- RvviAxiWlast  output  1  final word of the frame
- RvviAxiWvalid  output  1  data valid
- RvviAxiWready  input  1  MAC accepts the word
- Busy  output  1  frame in progress (any state but IDLE)
- Done  output  1  one-cycle pulse after the last word is accepted
- DropCount  output  8  Send requests ignored while busy; saturates at 255

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; word index = 0; header/message snapshot = 0.
  - RvviAxiWvalid=0, RvviAxiWlast=0, RvviAxiWdata=0, RvviAxiWstrb=0, Busy=0, Done=0, DropCount=0.
  - Reset mid-frame abandons the frame with no completion; the MAC must be reset with the block.
- States: IDLE, SEND, DONE.
- IDLE:
  - If Send=1 at an edge: snapshot FrameHeader and Message into registers, clear the word index, go to SEND.
  - RvviAxiWvalid rises the cycle after the Send edge (latency 1).
- SEND:
  - RvviAxiWvalid=1 throughout.
  - Word index k selects the data word:
    - k<5: snapshot header word k
    - k=5: snapshot message
    - k>5: 32'h0
  - RvviAxiWstrb=4'hF on every word.
  - RvviAxiWlast=1 only when k=NUM_WORDS-1.
  - A handshake occurs on an edge with RvviAxiWvalid & RvviAxiWready.
  - On a handshake with k<NUM_WORDS-1: k increments.
  - On a handshake with k=NUM_WORDS-1: go to DONE.
  - While valid is high and ready is low, data, strb and last hold stable. Valid never drops mid-frame except on reset.
  - Input changes on FrameHeader or Message after the snapshot do not affect the frame in flight.
- DONE:
  - Done=1 for exactly one cycle; valid=0, last=0; then go to IDLE.
  - Busy=1 in SEND and DONE.
- Send while Busy=1 (SEND or DONE): ignored, and DropCount increments by 1, saturating at 8'hFF. Held Send in IDLE after DONE starts a new frame.
- Minimum cycles between frame starts with ready tied high: NUM_WORDS+2.
- The word index is 8 bits; it never wraps within a frame.
- Outputs are registered where practical. RvviAxiWdata may be a mux of registered snapshot and index, with no combinational path from RvviAxiWready to data or last.

Test Plan:
- After reset, FrameHeader={32'h6e696769,32'h7274005c,32'h8f540000,32'h16544502,32'h11116843}, Message=32'hDEADBEEF, one-cycle Send, ready tied 1 -> valid high on cycles 1..15 after Send. Data sequence: 11116843, 16544502, 8f540000, 7274005c, 6e696769, DEADBEEF, then nine 00000000. Strb=F throughout, last only on word 15, Done pulses once on cycle 16, Busy low on cycle 17.
- Same frame with ready toggling 1,0,0,1,... -> exactly 15 handshakes. Data and last stable across every stall, no duplicated or skipped word.
- Change Message to 32'h12345678 two cycles after Send -> transmitted word 5 is still DEADBEEF.
- Send pulsed three more times while in SEND -> no extra frame and DropCount=3. Send in IDLE afterwards -> a new frame starts and DropCount stays 3.
- Assert reset at word 7 with ready=1 -> valid, last, Busy and Done go to 0 immediately (asynchronous). A following Send produces a complete 15-word frame from word 0.
- Hold Send high continuously with ready=1 -> back-to-back frames starting every 17 cycles. DropCount increments each SEND/DONE cycle, reaches 255 and stays there.
